// File: rtl/mapreduce_pkg.sv
// Shared types and helpers for the mapreduce byte path: arbiter states,
// default record delimiter and lane-index width.
package mapreduce_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam logic [7:0] DEFAULT_DELIM = 8'h0A;

    function automatic int lane_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request bit at or above the
// pointer, wrapping upward. Shared with the mapper dispatcher.
module rr_pick
    import mapreduce_pkg::*;
#(
    parameter int NUM_LANES = 4
) (
    input  logic [NUM_LANES-1:0]         i_req,
    input  logic [lane_w(NUM_LANES)-1:0] i_ptr,
    output logic [lane_w(NUM_LANES)-1:0] o_idx,
    output logic                         o_found
);

    localparam int LW = lane_w(NUM_LANES);

    int cand;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        cand    = 0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            cand = int'(i_ptr) + i;
            if (cand >= NUM_LANES) begin
                cand = cand - NUM_LANES;
            end
            if (i_req[cand]) begin
                o_idx   = LW'(cand);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reduce_lane_arbiter.sv
// Record-granular round-robin arbiter feeding the reducer from NUM_LANES byte
// FIFOs. Optional idle watchdog enabled by defining REDUCE_ARB_TIMEOUT_EN.
module reduce_lane_arbiter
    import mapreduce_pkg::*;
#(
    parameter int         NUM_LANES = 4,
    parameter logic [7:0] DELIM     = DEFAULT_DELIM,
    parameter int         MAX_REC   = 1024,
    parameter int         TIMEOUT   = 256
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_LANES-1:0]         i_lane_valid,
    output logic [NUM_LANES-1:0]         o_lane_rdy,
    input  logic [8*NUM_LANES-1:0]       i_lane_data,
    output logic [7:0]                   o_mst_data,
    output logic                         o_mst_valid,
    input  logic                         i_mst_rdy,
    output logic [lane_w(NUM_LANES)-1:0] o_mst_lane,
    output logic                         o_mst_last,
    output logic                         o_ovf,
    output logic                         o_timeout
);

    localparam int LW = lane_w(NUM_LANES);
    localparam int CW = $clog2(MAX_REC + 1);
    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_LOCK = LOCK;

    if (NUM_LANES < 2 || NUM_LANES > 16 || MAX_REC < 2 || TIMEOUT < 1) begin : g_bad_cfg
        $error("reduce_lane_arbiter: parameter out of range");
    end

    logic [0:0]    state_q, state_d;
    logic [LW-1:0] grant_q, grant_d;
    logic [LW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] rec_cnt_q, rec_cnt_d;
    logic          ovf_q, ovf_d;

    logic [LW-1:0] pick_idx;
    logic          pick_found;
    logic          sel_valid;
    logic [7:0]    sel_data;
    logic          active;
    logic          mst_valid;
    logic          cnt_hit;
    logic          mst_last;
    logic          xfer;
    logic          idle_release;
    logic [LW-1:0] next_ptr;

    rr_pick #(
        .NUM_LANES(NUM_LANES)
    ) u_pick (
        .i_req  (i_lane_valid),
        .i_ptr  (rr_ptr_q),
        .o_idx  (pick_idx),
        .o_found(pick_found)
    );

`ifdef REDUCE_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic          tmo_q, tmo_d;

    // Counts consecutive stalled LOCK cycles; the TIMEOUT-th one releases.
    always_comb begin
        idle_release = 1'b0;
        idle_cnt_d   = '0;
        tmo_d        = 1'b0;
        if (state_q == S_LOCK && !sel_valid) begin
            if (idle_cnt_q == TW'(TIMEOUT - 1)) begin
                idle_release = 1'b1;
                tmo_d        = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idle_cnt_q <= '0;
            tmo_q      <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    assign o_timeout = tmo_q && !i_rst;
`else
    assign idle_release = 1'b0;
    assign o_timeout    = 1'b0;
`endif

    // Zero-latency byte path from the granted lane.
    always_comb begin
        sel_valid = i_lane_valid[grant_q];
        sel_data  = i_lane_data[8*int'(grant_q) +: 8];
        active    = (state_q == S_LOCK) && !i_rst;
        mst_valid = active && sel_valid;
        cnt_hit   = (rec_cnt_q == CW'(MAX_REC - 1));
        mst_last  = mst_valid && ((sel_data == DELIM) || cnt_hit);
        xfer      = mst_valid && i_mst_rdy;
        next_ptr  = (grant_q == LW'(NUM_LANES - 1)) ? '0 : grant_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        rec_cnt_d = rec_cnt_q;
        ovf_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = S_LOCK;
                end
            end
            default: begin
                if (xfer) begin
                    rec_cnt_d = rec_cnt_q + 1'b1;
                    if (mst_last) begin
                        state_d   = S_IDLE;
                        rr_ptr_d  = next_ptr;
                        rec_cnt_d = '0;
                        // A delimiter landing on the final allowed byte is a clean end.
                        ovf_d     = cnt_hit && (sel_data != DELIM);
                    end
                end else if (idle_release) begin
                    state_d   = S_IDLE;
                    rr_ptr_d  = next_ptr;
                    rec_cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            rec_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            rec_cnt_q <= rec_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_mst_valid = mst_valid;
    assign o_mst_data  = active ? sel_data : 8'h00;
    assign o_mst_last  = mst_last;
    assign o_mst_lane  = i_rst ? '0 : grant_q;
    assign o_lane_rdy  = (active && i_mst_rdy) ? (NUM_LANES'(1) << grant_q) : '0;
    assign o_ovf       = ovf_q && !i_rst;

endmodule
